multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, max data-memory wait cycles before error; 0 disables the timeout.
REQ-002 Parameter OPCODE_W, default 5, opcode width; only value 5 is legal.
REQ-003 clk  input  1  the single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 instr_valid  input  1  fetch unit presents a valid opcode.
REQ-006 instr_ready  output  1  control accepts opcode; transfer occurs when instr_valid & instr_ready.
REQ-007 opcode  input  OPCODE_W  instruction opcode.
REQ-008 flag_lt, flag_eq  input  1 each  comparator flags from previous compare, sampled in EXEC.
REQ-009 mem_ready  input  1  data memory completes the access in the current cycle.
REQ-010 alu_mode  output  ALU_MODE_COUNT  one-hot ALU mode.
REQ-011 alu_a_sel, alu_b_sel  output  1 each  A: 0 accumulator/1 PC; B: 0 register/1 immediate.
REQ-012 rf_write_en, rf_write_data_sel, rf_write_addr_sel  output  1 each  register-file write enable, data source (1 = memory), address source.
REQ-013 mem_read_en, mem_write_en  output  1 each  data-memory strobes.
REQ-014 pc_write_en  output  1  load PC from ALU result.
REQ-015 illegal_op, mem_timeout  output  1 each  one-cycle error pulses.

Function
REQ-016 FSM states: FETCH, EXEC, MEM, WB; encoding is free.
REQ-017 FETCH: instr_ready=1; on handshake, latch opcode into op_q and go to EXEC; otherwise stay.
REQ-018 Decode uses op_q only; a changing opcode input after the handshake has no effect.
REQ-019 Classes by op_q[4:1]: 000x add/addi; 001x sh/shi; 0100 not; 0101 and; 0110 or; 0111 xor; 1000 cpy (bit0=1 cpypc); 1001 lb; 1010 sb; 1011 jmpadr; op_q[4:3]=11 control flow, with op_q[2:0] 000 jmpi, 001 blt, 010 bge, 011 beq, 100 bneq.
REQ-020 alu_mode: ADD for add/addi and control flow; SHIFT for sh/shi; NOT/AND/OR/XOR as named; BYPASS_A for cpy, cpypc, lb, sb, jmpadr.
REQ-021 alu_b_sel=1 for addi, shi and control flow; alu_a_sel=1 for control flow and cpypc.
REQ-022 ALU/cpy classes: EXEC -> WB -> FETCH, with rf_write_en=1 in WB only; rf_write_addr_sel=1 for op_q[4:2]=100 classes.
REQ-023 lb: EXEC -> MEM; in MEM, mem_read_en=1 until mem_ready; then WB with rf_write_data_sel=1 and rf_write_en=1 -> FETCH.
REQ-024 sb: EXEC -> MEM; in MEM, mem_write_en=1 until mem_ready; then -> FETCH; no register write.
REQ-025 Control flow: in EXEC, pc_write_en=1 for jmpi/jmpadr, flag_lt (blt), ~flag_lt (bge), flag_eq (beq), ~flag_eq (bneq); then -> FETCH.
REQ-026 Illegal op_q (11101, 11110, 11111): illegal_op pulses 1 in EXEC, no strobes asserted, -> FETCH.
REQ-027 Latency from handshake to next instr_ready: ALU 3 cycles; branch 2; sb 3+wait; lb 4+wait.
REQ-028 Wait counter counts MEM cycles with mem_ready=0. On reaching MEM_TIMEOUT: mem_timeout pulses, the strobe drops, and the FSM goes to FETCH with no WB.
REQ-029 mem_ready in the first MEM cycle completes with zero wait; the counter clears on MEM entry.
REQ-030 All strobes (rf_write_en, mem_*_en, pc_write_en, error pulses) are 0 outside the states named above; alu_mode/select outputs are don't-care outside EXEC/WB/MEM but deterministic.

Reset
REQ-031 rst_n=0 at a clock edge: state=FETCH, op_q=0, wait counter=0.
REQ-032 During and after reset: all strobes and error pulses 0; instr_ready=1 from the first cycle after release.
REQ-033 Reset in MEM or WB aborts the instruction; no write occurs in that cycle or afterwards.

Structure
REQ-034 ALU_MODE_* one-hot constants and ALU_MODE_COUNT reside in shared param.vh; opcode class constants and state encodings are added there too.
REQ-035 The decoder (op_q to alu_mode/selects/class flags) is a combinational sub-module, control_decode; the FSM and counter live in multicycle_control.

Verification
REQ-036 Sequence: add 00000 handshake -> EXEC, WB (rf_write_en=1 exactly one cycle) -> instr_ready high 3 cycles after handshake.
REQ-037 Sequence: lb 10010 with mem_ready low 2 cycles -> mem_read_en high 3 cycles; then WB with rf_write_data_sel=1, rf_write_en=1.
REQ-038 Sequence: beq 11011 with flag_eq=1 -> pc_write_en=1 in EXEC; same opcode with flag_eq=0 -> pc_write_en stays 0; both return to FETCH after 2 cycles.
REQ-039 Sequence: sb with mem_ready held 0 and MEM_TIMEOUT=15 -> mem_write_en high 15 cycles, mem_timeout one pulse, no rf_write_en, FSM back in FETCH.
REQ-040 Sequences: opcode 11111 -> illegal_op one pulse with all strobes 0; rst_n=0 during lb MEM -> FSM in FETCH, no rf_write_en.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg
// Shared definitions for the multicycle control unit:
//   - one-hot ALU mode constants and the mode vector width
//   - FSM state encoding
//   - opcode class and PC-write condition encodings produced by the decoder
//   - helper that resolves a PC-write condition against the comparator flags
package multicycle_control_pkg;

    localparam int ALU_MODE_COUNT = 7;

    localparam logic [ALU_MODE_COUNT-1:0] ALU_MODE_ADD      = 7'b000_0001;
    localparam logic [ALU_MODE_COUNT-1:0] ALU_MODE_SHIFT    = 7'b000_0010;
    localparam logic [ALU_MODE_COUNT-1:0] ALU_MODE_NOT      = 7'b000_0100;
    localparam logic [ALU_MODE_COUNT-1:0] ALU_MODE_AND      = 7'b000_1000;
    localparam logic [ALU_MODE_COUNT-1:0] ALU_MODE_OR       = 7'b001_0000;
    localparam logic [ALU_MODE_COUNT-1:0] ALU_MODE_XOR      = 7'b010_0000;
    localparam logic [ALU_MODE_COUNT-1:0] ALU_MODE_BYPASS_A = 7'b100_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_WB    = 2'd3
    } state_e;

    // Instruction flow class: decides which states follow EXEC.
    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,  // EXEC -> WB -> FETCH (ALU ops, cpy, cpypc)
        CLS_LB      = 3'd1,  // EXEC -> MEM -> WB -> FETCH
        CLS_SB      = 3'd2,  // EXEC -> MEM -> FETCH
        CLS_FLOW    = 3'd3,  // EXEC -> FETCH, may write PC
        CLS_ILLEGAL = 3'd4   // EXEC -> FETCH, error pulse only
    } op_class_e;

    typedef enum logic [2:0] {
        PC_NEVER  = 3'd0,
        PC_ALWAYS = 3'd1,
        PC_LT     = 3'd2,
        PC_GE     = 3'd3,
        PC_EQ     = 3'd4,
        PC_NE     = 3'd5
    } pc_cond_e;

    // Resolve a PC-write condition against the comparator flags.
    function automatic logic pc_taken(input pc_cond_e cond, input logic lt, input logic eq);
        logic taken;
        case (cond)
            PC_ALWAYS: taken = 1'b1;
            PC_LT:     taken = lt;
            PC_GE:     taken = ~lt;
            PC_EQ:     taken = eq;
            PC_NE:     taken = ~eq;
            default:   taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode
// Purely combinational opcode decoder for the multicycle control unit.
// Ports:
//   op_i                - latched opcode (5 bits)
//   alu_mode_o          - one-hot ALU mode
//   alu_a_sel_o         - ALU A source (0 accumulator, 1 PC)
//   alu_b_sel_o         - ALU B source (0 register, 1 immediate)
//   rf_write_addr_sel_o - register-file write address source
//   cls_o               - flow class that steers the FSM after EXEC
//   pc_cond_o           - condition under which PC is loaded in EXEC
module control_decode
    import multicycle_control_pkg::*;
(
    input  logic [4:0]                op_i,
    output logic [ALU_MODE_COUNT-1:0] alu_mode_o,
    output logic                      alu_a_sel_o,
    output logic                      alu_b_sel_o,
    output logic                      rf_write_addr_sel_o,
    output op_class_e                 cls_o,
    output pc_cond_e                  pc_cond_o
);

    // Opcode to datapath controls and flow class.
    always_comb begin
        alu_mode_o          = ALU_MODE_ADD;
        alu_a_sel_o         = 1'b0;
        alu_b_sel_o         = 1'b0;
        cls_o               = CLS_ALU;
        pc_cond_o           = PC_NEVER;
        // cpy/cpypc and lb share the alternate write-address source.
        rf_write_addr_sel_o = (op_i[4:2] == 3'b100);

        if (op_i[4:3] == 2'b11) begin
            // Control flow computes PC + immediate on the adder.
            alu_mode_o  = ALU_MODE_ADD;
            alu_a_sel_o = 1'b1;
            alu_b_sel_o = 1'b1;
            cls_o       = CLS_FLOW;
            case (op_i[2:0])
                3'b000:  pc_cond_o = PC_ALWAYS;
                3'b001:  pc_cond_o = PC_LT;
                3'b010:  pc_cond_o = PC_GE;
                3'b011:  pc_cond_o = PC_EQ;
                3'b100:  pc_cond_o = PC_NE;
                default: begin
                    pc_cond_o = PC_NEVER;
                    cls_o     = CLS_ILLEGAL;
                end
            endcase
        end else begin
            case (op_i[4:1])
                4'b0000: alu_mode_o = ALU_MODE_ADD;
                4'b0001: begin
                    alu_mode_o  = ALU_MODE_ADD;
                    alu_b_sel_o = 1'b1;
                end
                4'b0010: alu_mode_o = ALU_MODE_SHIFT;
                4'b0011: begin
                    alu_mode_o  = ALU_MODE_SHIFT;
                    alu_b_sel_o = 1'b1;
                end
                4'b0100: alu_mode_o = ALU_MODE_NOT;
                4'b0101: alu_mode_o = ALU_MODE_AND;
                4'b0110: alu_mode_o = ALU_MODE_OR;
                4'b0111: alu_mode_o = ALU_MODE_XOR;
                4'b1000: begin
                    // bit0 selects cpypc, which copies the PC instead.
                    alu_mode_o  = ALU_MODE_BYPASS_A;
                    alu_a_sel_o = op_i[0];
                end
                4'b1001: begin
                    alu_mode_o = ALU_MODE_BYPASS_A;
                    cls_o      = CLS_LB;
                end
                4'b1010: begin
                    alu_mode_o = ALU_MODE_BYPASS_A;
                    cls_o      = CLS_SB;
                end
                4'b1011: begin
                    alu_mode_o = ALU_MODE_BYPASS_A;
                    cls_o      = CLS_FLOW;
                    pc_cond_o  = PC_ALWAYS;
                end
                default: begin
                    alu_mode_o = ALU_MODE_ADD;
                    cls_o      = CLS_ILLEGAL;
                end
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// FETCH/EXEC/MEM/WB control FSM for a small multicycle processor, with a
// data-memory wait counter that aborts stalled accesses.
// Parameters: MEM_TIMEOUT (max MEM wait cycles, 0 = no timeout),
//             OPCODE_W (must be 5).
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   instr_valid/ready    - opcode handshake from the fetch unit
//   opcode               - opcode, latched on handshake
//   flag_lt, flag_eq     - comparator flags used by branches in EXEC
//   mem_ready            - data memory completes the access this cycle
//   alu_mode, alu_*_sel  - datapath controls from the decoder
//   rf_write_*           - register-file write enable / data / address selects
//   mem_read_en/write_en - data-memory strobes
//   pc_write_en          - load PC from the ALU result
//   illegal_op, mem_timeout - one-cycle error pulses
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int OPCODE_W    = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [OPCODE_W-1:0]       opcode,
    input  logic                      flag_lt,
    input  logic                      flag_eq,
    input  logic                      mem_ready,
    output logic [ALU_MODE_COUNT-1:0] alu_mode,
    output logic                      alu_a_sel,
    output logic                      alu_b_sel,
    output logic                      rf_write_en,
    output logic                      rf_write_data_sel,
    output logic                      rf_write_addr_sel,
    output logic                      mem_read_en,
    output logic                      mem_write_en,
    output logic                      pc_write_en,
    output logic                      illegal_op,
    output logic                      mem_timeout
);

    // Counter only has to reach MEM_TIMEOUT-1: the next unready cycle aborts.
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e                  state_q, state_d;
    logic [OPCODE_W-1:0]     op_q, op_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [ALU_MODE_COUNT-1:0] dec_mode_s;
    logic                      dec_a_sel_s;
    logic                      dec_b_sel_s;
    logic                      dec_addr_sel_s;
    op_class_e                 cls_s;
    pc_cond_e                  pc_cond_s;
    logic                      timeout_hit_s;

    control_decode u_decode (
        .op_i                (op_q),
        .alu_mode_o          (dec_mode_s),
        .alu_a_sel_o         (dec_a_sel_s),
        .alu_b_sel_o         (dec_b_sel_s),
        .rf_write_addr_sel_o (dec_addr_sel_s),
        .cls_o               (cls_s),
        .pc_cond_o           (pc_cond_s)
    );

    // Another unready cycle at the last allowed count ends the access.
    assign timeout_hit_s = (MEM_TIMEOUT != 0) && !mem_ready && (cnt_q == TO_LAST);

    // State, latched opcode and wait counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            op_q    <= {OPCODE_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; the counter is zero whenever the FSM is not waiting in MEM.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = {CNT_W{1'b0}};
        case (state_q)
            ST_FETCH: begin
                if (instr_valid) begin
                    op_d    = opcode;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                case (cls_s)
                    CLS_ALU:         state_d = ST_WB;
                    CLS_LB, CLS_SB:  state_d = ST_MEM;
                    default:         state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = (cls_s == CLS_LB) ? ST_WB : ST_FETCH;
                end else if (timeout_hit_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_MEM;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = ST_FETCH;
        endcase
    end

    // Outputs; everything is forced low while rst_n is asserted so an
    // in-flight MEM or WB cannot write during the reset cycle.
    always_comb begin
        alu_mode          = dec_mode_s;
        alu_a_sel         = dec_a_sel_s;
        alu_b_sel         = dec_b_sel_s;
        rf_write_addr_sel = dec_addr_sel_s;
        rf_write_data_sel = (cls_s == CLS_LB);
        instr_ready       = 1'b0;
        rf_write_en       = 1'b0;
        mem_read_en       = 1'b0;
        mem_write_en      = 1'b0;
        pc_write_en       = 1'b0;
        illegal_op        = 1'b0;
        mem_timeout       = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: instr_ready = 1'b1;
                ST_EXEC: begin
                    pc_write_en = pc_taken(pc_cond_s, flag_lt, flag_eq);
                    illegal_op  = (cls_s == CLS_ILLEGAL);
                end
                ST_MEM: begin
                    mem_read_en  = (cls_s == CLS_LB);
                    mem_write_en = (cls_s == CLS_SB);
                    mem_timeout  = timeout_hit_s;
                end
                ST_WB:   rf_write_en = 1'b1;
                default: instr_ready = 1'b0;
            endcase
        end else begin
            instr_ready = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int TO = 15;

    logic                      clk;
    logic                      rst_n;
    logic                      instr_valid;
    logic                      instr_ready;
    logic [4:0]                opcode;
    logic                      flag_lt;
    logic                      flag_eq;
    logic                      mem_ready;
    logic [ALU_MODE_COUNT-1:0] alu_mode;
    logic                      alu_a_sel;
    logic                      alu_b_sel;
    logic                      rf_write_en;
    logic                      rf_write_data_sel;
    logic                      rf_write_addr_sel;
    logic                      mem_read_en;
    logic                      mem_write_en;
    logic                      pc_write_en;
    logic                      illegal_op;
    logic                      mem_timeout;

    int total = 0;
    int bad   = 0;

    multicycle_control #(.MEM_TIMEOUT(TO), .OPCODE_W(5)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .opcode            (opcode),
        .flag_lt           (flag_lt),
        .flag_eq           (flag_eq),
        .mem_ready         (mem_ready),
        .alu_mode          (alu_mode),
        .alu_a_sel         (alu_a_sel),
        .alu_b_sel         (alu_b_sel),
        .rf_write_en       (rf_write_en),
        .rf_write_data_sel (rf_write_data_sel),
        .rf_write_addr_sel (rf_write_addr_sel),
        .mem_read_en       (mem_read_en),
        .mem_write_en      (mem_write_en),
        .pc_write_en       (pc_write_en),
        .illegal_op        (illegal_op),
        .mem_timeout       (mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

    // One expected cycle after the handshake.
    typedef struct {
        logic mr;      // mem_ready to drive in this cycle
        logic rfw;
        logic mrd;
        logic mwr;
        logic pcw;
        logic ill;
        logic to;
        logic is_exec;
        logic is_wb;
    } rec_t;

    rec_t exp_q[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_mode(input int op);
        case (op / 2)
            0, 1:         return ALU_MODE_ADD;
            2, 3:         return ALU_MODE_SHIFT;
            4:            return ALU_MODE_NOT;
            5:            return ALU_MODE_AND;
            6:            return ALU_MODE_OR;
            7:            return ALU_MODE_XOR;
            8, 9, 10, 11: return ALU_MODE_BYPASS_A;
            default:      return ALU_MODE_ADD;
        endcase
    endfunction

    // Expected cycle list for one instruction, from the instruction rules.
    task automatic build(input int op, input logic lt, input logic eq, input int waitc);
        rec_t r;
        bit   is_lb   = (op == 18) || (op == 19);
        bit   is_sb   = (op == 20) || (op == 21);
        bit   is_flow = (op >= 22);
        bit   illegal = (op >= 29);
        bit   timed   = 1'b0;
        bit   taken   = (op >= 22 && op <= 24) || (op == 25 && lt) || (op == 26 && !lt) ||
                        (op == 27 && eq) || (op == 28 && !eq);
        exp_q.delete();
        r = '{default: 1'b0};
        r.is_exec = 1'b1;
        r.pcw     = taken;
        r.ill     = illegal;
        exp_q.push_back(r);
        if (is_lb || is_sb) begin
            for (int i = 0; i < 1000; i++) begin
                bit done;
                r = '{default: 1'b0};
                r.mr  = (i >= waitc);
                r.mrd = is_lb;
                r.mwr = is_sb;
                done  = r.mr;
                if (!r.mr && i == TO - 1) begin
                    r.to  = 1'b1;
                    done  = 1'b1;
                    timed = 1'b1;
                end
                exp_q.push_back(r);
                if (done) break;
            end
        end
        if ((is_lb && !timed) || (!is_flow && !is_lb && !is_sb)) begin
            r = '{default: 1'b0};
            r.rfw   = 1'b1;
            r.is_wb = 1'b1;
            exp_q.push_back(r);
        end
    endtask

    // Called #1 after a rising edge with the DUT expected to be in FETCH.
    task automatic run(input int op, input logic lt, input logic eq, input int waitc);
        build(op, lt, eq, waitc);
        instr_valid = 1'b1;
        opcode      = 5'(op);
        flag_lt     = lt;
        flag_eq     = eq;
        mem_ready   = 1'b0;
        @(negedge clk);
        check($sformatf("hs_ready op=%0d", op), {7'd0, instr_ready}, 8'd1);
        check($sformatf("hs_strobes op=%0d", op),
              {2'd0, rf_write_en, mem_read_en, mem_write_en, pc_write_en, illegal_op, mem_timeout}, 8'd0);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        foreach (exp_q[k]) begin
            opcode    = 5'($urandom_range(0, 31));
            mem_ready = exp_q[k].mr;
            @(negedge clk);
            check($sformatf("busy_ready op=%0d cyc=%0d", op, k), {7'd0, instr_ready}, 8'd0);
            check($sformatf("strobes op=%0d cyc=%0d", op, k),
                  {2'd0, rf_write_en, mem_read_en, mem_write_en, pc_write_en, illegal_op, mem_timeout},
                  {2'd0, exp_q[k].rfw, exp_q[k].mrd, exp_q[k].mwr, exp_q[k].pcw, exp_q[k].ill, exp_q[k].to});
            if (exp_q[k].is_exec && op < 29) begin
                check($sformatf("exec_mode op=%0d", op), {1'b0, alu_mode}, {1'b0, ref_mode(op)});
                check($sformatf("exec_sel op=%0d", op), {5'd0, alu_a_sel, alu_b_sel, rf_write_addr_sel},
                      {5'd0, 1'(op >= 24 || op == 17),
                       1'(op >= 24 || op == 2 || op == 3 || op == 6 || op == 7),
                       1'(op >= 16 && op <= 19)});
            end
            if (exp_q[k].is_wb) begin
                check($sformatf("wb_dsel op=%0d", op), {7'd0, rf_write_data_sel},
                      {7'd0, 1'(op == 18 || op == 19)});
            end
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        opcode      = 5'd0;
        flag_lt     = 1'b0;
        flag_eq     = 1'b0;
        mem_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_strobes",
              {1'b0, instr_ready, rf_write_en, mem_read_en, mem_write_en, pc_write_en, illegal_op, mem_timeout},
              8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {7'd0, instr_ready}, 8'd1);
        @(posedge clk);
        #1;

        // Directed sequences.
        run(0, 1'b0, 1'b0, 0);       // add
        run(18, 1'b0, 1'b0, 2);      // lb with two wait cycles
        run(27, 1'b0, 1'b1, 0);      // beq taken
        run(27, 1'b0, 1'b0, 0);      // beq not taken
        run(20, 1'b0, 1'b0, 1000);   // sb timing out
        run(31, 1'b0, 1'b0, 0);      // illegal
        run(29, 1'b1, 1'b1, 0);      // illegal
        run(22, 1'b0, 1'b0, 0);      // jmpadr
        run(17, 1'b0, 1'b0, 0);      // cpypc
        run(18, 1'b0, 1'b0, 14);     // lb completing on the last allowed cycle
        run(21, 1'b0, 1'b0, 0);      // sb, zero wait

        // Reset while lb is waiting in MEM.
        instr_valid = 1'b1;
        opcode      = 5'd18;
        mem_ready   = 1'b0;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rstmem_rd_before", {7'd0, mem_read_en}, 8'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmem_during",
              {1'b0, instr_ready, rf_write_en, mem_read_en, mem_write_en, pc_write_en, illegal_op, mem_timeout},
              8'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("rstmem_after", {6'd0, instr_ready, rf_write_en}, 8'd2);
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("rstmem_after2", {5'd0, instr_ready, rf_write_en, mem_read_en}, 8'd4);
        @(posedge clk);
        #1;

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            run(int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 17)));
        end

        @(negedge clk);
        check("final_ready", {7'd0, instr_ready}, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
